// File: rtl/calc_key_arbiter.sv
// Arbitrates keypad and UART key events onto the calculator's single key-pulse input.
// Round-robin over two private FIFOs, illegal-code filtering, and a pre-emptive flushing clear key.
module calc_key_arbiter #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned GAP_CYCLES = 2,
  parameter int unsigned GAP_W      = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       kp_valid,
  input  logic [7:0] kp_char,
  output logic       kp_ready,
  input  logic       ux_valid,
  input  logic [7:0] ux_char,
  output logic       ux_ready,
  output logic       btn_valid,
  output logic [7:0] btn_char,
  output logic       busy,
  output logic [7:0] err_count
);

  localparam int unsigned AW       = $clog2(FIFO_DEPTH);
  localparam logic [7:0]  KeyClear = 8'h43;
  localparam logic [AW:0] PtrOne   = (AW + 1)'(1);

  typedef enum logic {StIdle, StGap} state_e;

  state_e           state_q;
  logic [GAP_W-1:0] gap_cnt_q;
  logic             clear_pending_q;
  logic             last_ux_q;
  logic [7:0]       kp_mem_q [FIFO_DEPTH];
  logic [7:0]       ux_mem_q [FIFO_DEPTH];
  logic [AW:0]      kp_wr_q, kp_rd_q, ux_wr_q, ux_rd_q;

  logic       kp_empty, kp_full, ux_empty, ux_full;
  logic       kp_acc, ux_acc, clr_acc;
  logic       kp_push, ux_push, kp_err, ux_err;
  logic       pop_kp, pop_ux;
  logic [8:0] err_sum;

  function automatic logic is_legal(input logic [7:0] c);
    return c inside {[8'h30:8'h39], 8'h2a, 8'h2b, 8'h2d, 8'h3d, 8'h43, 8'h08};
  endfunction

  always_comb begin
    kp_empty = (kp_wr_q == kp_rd_q);
    ux_empty = (ux_wr_q == ux_rd_q);
    kp_full  = (kp_wr_q[AW] != kp_rd_q[AW]) && (kp_wr_q[AW-1:0] == kp_rd_q[AW-1:0]);
    ux_full  = (ux_wr_q[AW] != ux_rd_q[AW]) && (ux_wr_q[AW-1:0] == ux_rd_q[AW-1:0]);
    kp_ready = !kp_full && !clear_pending_q;
    ux_ready = !ux_full && !clear_pending_q;

    kp_acc  = kp_valid && kp_ready;
    ux_acc  = ux_valid && ux_ready;
    // A clear swallows whatever the other source delivers in the same cycle, legal or not.
    clr_acc = (kp_acc && (kp_char == KeyClear)) || (ux_acc && (ux_char == KeyClear));
    kp_push = kp_acc && !clr_acc && is_legal(kp_char);
    ux_push = ux_acc && !clr_acc && is_legal(ux_char);
    kp_err  = kp_acc && !clr_acc && !is_legal(kp_char);
    ux_err  = ux_acc && !clr_acc && !is_legal(ux_char);

    pop_kp = (state_q == StIdle) && !clear_pending_q && !kp_empty && (ux_empty || last_ux_q);
    pop_ux = (state_q == StIdle) && !clear_pending_q && !ux_empty && (kp_empty || !last_ux_q);

    err_sum = {1'b0, err_count} + {8'd0, kp_err} + {8'd0, ux_err};
    busy    = !kp_empty || !ux_empty || clear_pending_q || (state_q != StIdle);
  end

  always_ff @(posedge clk) begin
    if (kp_push) kp_mem_q[kp_wr_q[AW-1:0]] <= kp_char;
    if (ux_push) ux_mem_q[ux_wr_q[AW-1:0]] <= ux_char;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= StIdle;
      gap_cnt_q       <= '0;
      clear_pending_q <= 1'b0;
      last_ux_q       <= 1'b1;
      kp_wr_q         <= '0;
      kp_rd_q         <= '0;
      ux_wr_q         <= '0;
      ux_rd_q         <= '0;
      btn_valid       <= 1'b0;
      btn_char        <= '0;
      err_count       <= '0;
    end else begin
      err_count <= err_sum[8] ? 8'hff : err_sum[7:0];

      case (state_q)
        StIdle: begin
          btn_valid <= 1'b0;
          if (clear_pending_q) begin
            btn_valid       <= 1'b1;
            btn_char        <= KeyClear;
            clear_pending_q <= 1'b0;
            gap_cnt_q       <= GAP_W'(GAP_CYCLES);
            state_q         <= StGap;
          end else if (pop_kp) begin
            btn_valid <= 1'b1;
            btn_char  <= kp_mem_q[kp_rd_q[AW-1:0]];
            last_ux_q <= 1'b0;
            gap_cnt_q <= GAP_W'(GAP_CYCLES);
            state_q   <= StGap;
          end else if (pop_ux) begin
            btn_valid <= 1'b1;
            btn_char  <= ux_mem_q[ux_rd_q[AW-1:0]];
            last_ux_q <= 1'b1;
            gap_cnt_q <= GAP_W'(GAP_CYCLES);
            state_q   <= StGap;
          end
        end
        StGap: begin
          btn_valid <= 1'b0;
          gap_cnt_q <= gap_cnt_q - GAP_W'(1);
          if (gap_cnt_q <= GAP_W'(1)) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase

      // Flush overrides any push/pop on the same edge; a pop still emits its already-read head.
      if (clr_acc) begin
        clear_pending_q <= 1'b1;
        kp_wr_q         <= '0;
        kp_rd_q         <= '0;
        ux_wr_q         <= '0;
        ux_rd_q         <= '0;
      end else begin
        if (kp_push) kp_wr_q <= kp_wr_q + PtrOne;
        if (ux_push) ux_wr_q <= ux_wr_q + PtrOne;
        if (pop_kp)  kp_rd_q <= kp_rd_q + PtrOne;
        if (pop_ux)  ux_rd_q <= ux_rd_q + PtrOne;
      end
    end
  end

endmodule

// File: tb/tb_calc_key_arbiter.sv
// Self-checking bench for calc_key_arbiter: directed vector table, corner sequences,
// and a randomized run scored against a queue-based model of the key arbitration rules.
module tb_calc_key_arbiter;

  localparam int Depth = 4;
  localparam int Gap   = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       kp_valid = 1'b0, ux_valid = 1'b0;
  logic [7:0] kp_char = '0, ux_char = '0;
  logic       kp_ready, ux_ready, btn_valid, busy;
  logic [7:0] btn_char, err_count;

  calc_key_arbiter #(.FIFO_DEPTH(Depth), .GAP_CYCLES(Gap), .GAP_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .kp_valid(kp_valid), .kp_char(kp_char), .kp_ready(kp_ready),
    .ux_valid(ux_valid), .ux_char(ux_char), .ux_ready(ux_ready),
    .btn_valid(btn_valid), .btn_char(btn_char), .busy(busy), .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; logic [7:0] ch; } pulse_t;
  pulse_t pulses[$];
  int     cyc = 0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (rst_n && btn_valid) pulses.push_back('{cyc: cyc, ch: btn_char});
  end

  int n_pass = 0, n_total = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic reset_dut();
    kp_valid = 0; ux_valid = 0; kp_char = 0; ux_char = 0;
    rst_n = 0;
    step(); step();
    rst_n = 1;
    step();
  endtask

  function automatic bit legal(input logic [7:0] c);
    string s = "0123456789+-*=C";
    for (int i = 0; i < s.len(); i++) if (c == s[i]) return 1'b1;
    return c == 8'h08;
  endfunction

  function automatic logic [7:0] rand_key();
    string s = "0123456789+-*=";
    int    r = $urandom_range(0, 99);
    if (r < 3) return "C";
    if (r < 8) return 8'h08;
    if (r < 85) return s[$urandom_range(0, 13)];
    return 8'($urandom_range(0, 255));
  endfunction

  // Reference model: per-source key queues, pending clear, last grant, error tally.
  logic [7:0] mkq[$], muq[$];
  bit         m_clr, m_last_ux, seen;
  int         m_err, low_run;
  bit         pk_acc, pu_acc;
  logic [7:0] pk_c, pu_c;

  task automatic model_step(input bit drive);
    logic [7:0] exp_c;
    bit exp_kr, exp_ur;
    step();
    if (btn_valid) begin
      if (seen) chk("rand_gap", int'(low_run >= Gap), 1);
      seen = 1; low_run = 0;
      if (m_clr) begin
        exp_c = "C"; m_clr = 0;
      end else if (mkq.size() > 0 && (muq.size() == 0 || m_last_ux)) begin
        exp_c = mkq.pop_front(); m_last_ux = 0;
      end else if (muq.size() > 0) begin
        exp_c = muq.pop_front(); m_last_ux = 1;
      end else begin
        exp_c = 8'hee;  // nothing was available to pulse
      end
      chk("rand_char", btn_char, exp_c);
    end else begin
      low_run++;
    end
    if ((pk_acc && pk_c == "C") || (pu_acc && pu_c == "C")) begin
      mkq.delete(); muq.delete(); m_clr = 1;
    end else begin
      if (pk_acc) begin
        if (legal(pk_c)) mkq.push_back(pk_c); else m_err++;
      end
      if (pu_acc) begin
        if (legal(pu_c)) muq.push_back(pu_c); else m_err++;
      end
      if (m_err > 255) m_err = 255;
    end
    exp_kr = (mkq.size() < Depth) && !m_clr;
    exp_ur = (muq.size() < Depth) && !m_clr;
    chk("rand_err", err_count, m_err);
    chk("rand_kp_ready", kp_ready, exp_kr);
    chk("rand_ux_ready", ux_ready, exp_ur);
    kp_valid = drive && ($urandom_range(0, 1) == 1);
    ux_valid = drive && ($urandom_range(0, 1) == 1);
    kp_char  = rand_key();
    ux_char  = rand_key();
    pk_acc = kp_valid && exp_kr; pk_c = kp_char;
    pu_acc = ux_valid && exp_ur; pu_c = ux_char;
  endtask

  typedef struct {
    logic kv; logic [7:0] kc; logic uv; logic [7:0] uc;
    int n; logic [7:0] e0; logic [7:0] e1; int err;
  } vec_t;
  vec_t vecs[12];

  initial begin
    int n0, nk, nu, bad_alt;
    bit seen_k, seen_u;
    string seq;

    vecs[0]  = '{1'b1, "1",   1'b0, 8'h00, 1, "1",   8'h00, 0};
    vecs[1]  = '{1'b0, 8'h00, 1'b1, 8'h08, 1, 8'h08, 8'h00, 0};
    vecs[2]  = '{1'b1, "x",   1'b0, 8'h00, 0, 8'h00, 8'h00, 1};
    vecs[3]  = '{1'b1, "9",   1'b1, "C",   1, "C",   8'h00, 0};
    vecs[4]  = '{1'b1, "C",   1'b1, "C",   1, "C",   8'h00, 0};
    vecs[5]  = '{1'b1, "q",   1'b1, 8'h00, 0, 8'h00, 8'h00, 2};
    vecs[6]  = '{1'b1, "5",   1'b1, "7",   2, "5",   "7",   0};
    vecs[7]  = '{1'b1, "C",   1'b1, "x",   1, "C",   8'h00, 0};
    vecs[8]  = '{1'b1, "=",   1'b1, "+",   2, "=",   "+",   0};
    vecs[9]  = '{1'b0, 8'h00, 1'b1, "*",   1, "*",   8'h00, 0};
    vecs[10] = '{1'b1, "c",   1'b0, 8'h00, 0, 8'h00, 8'h00, 1};
    vecs[11] = '{1'b1, "-",   1'b1, "z",   1, "-",   8'h00, 1};

    // Reset state.
    reset_dut();
    chk("rst_btn_valid", btn_valid, 0);
    chk("rst_btn_char", btn_char, 0);
    chk("rst_err", err_count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_kp_ready", kp_ready, 1);
    chk("rst_ux_ready", ux_ready, 1);

    // Single-cycle vectors from a freshly reset arbiter.
    for (int i = 0; i < 12; i++) begin
      reset_dut();
      pulses.delete();
      n0 = cyc;
      kp_valid = vecs[i].kv; kp_char = vecs[i].kc;
      ux_valid = vecs[i].uv; ux_char = vecs[i].uc;
      step();
      kp_valid = 0; ux_valid = 0;
      repeat (12) step();
      chk($sformatf("vec%0d_count", i), pulses.size(), vecs[i].n);
      if (vecs[i].n > 0 && pulses.size() > 0) begin
        chk($sformatf("vec%0d_char0", i), pulses[0].ch, vecs[i].e0);
        chk($sformatf("vec%0d_lat0", i), pulses[0].cyc, n0 + 2);
      end
      if (vecs[i].n > 1 && pulses.size() > 1) begin
        chk($sformatf("vec%0d_char1", i), pulses[1].ch, vecs[i].e1);
        chk($sformatf("vec%0d_lat1", i), pulses[1].cyc, n0 + 5);
      end
      chk($sformatf("vec%0d_err", i), err_count, vecs[i].err);
    end

    // Back-to-back keypad stream: exact spacing of GAP_CYCLES+1.
    seq = "12+3=";
    reset_dut();
    pulses.delete();
    n0 = cyc;
    for (int i = 0; i < 5; i++) begin
      kp_valid = 1; kp_char = seq[i];
      chk("seq_kp_ready", kp_ready, 1);
      step();
    end
    kp_valid = 0;
    repeat (20) step();
    chk("seq_count", pulses.size(), 5);
    for (int i = 0; i < 5 && i < pulses.size(); i++) begin
      chk($sformatf("seq_char%0d", i), pulses[i].ch, seq[i]);
      chk($sformatf("seq_time%0d", i), pulses[i].cyc, n0 + 2 + 3 * i);
    end
    chk("seq_busy_after", busy, 0);

    // Both sources saturating: alternation, backpressure, no loss.
    reset_dut();
    pulses.delete();
    nk = 0; nu = 0; seen_k = 0; seen_u = 0;
    for (int i = 0; i < 40; i++) begin
      kp_valid = 1; kp_char = "1";
      ux_valid = 1; ux_char = "2";
      nk += int'(kp_ready); nu += int'(ux_ready);
      if (!kp_ready) seen_k = 1;
      if (!ux_ready) seen_u = 1;
      step();
    end
    kp_valid = 0; ux_valid = 0;
    repeat (60) step();
    chk("rr_count", pulses.size(), nk + nu);
    chk("rr_kp_backpressure", seen_k, 1);
    chk("rr_ux_backpressure", seen_u, 1);
    bad_alt = 0;
    for (int i = 0; i < pulses.size(); i++)
      if (pulses[i].ch != ((i % 2 == 0) ? 8'h31 : 8'h32)) bad_alt++;
    chk("rr_alternation_errors", bad_alt, 0);
    chk("rr_busy_after", busy, 0);

    // Clear arriving during a gap flushes queued keys; readies low while clear pends.
    reset_dut();
    pulses.delete();
    n0 = cyc;
    kp_valid = 1; kp_char = "1"; step();
    kp_char = "5"; step();
    kp_char = "6"; ux_valid = 1; ux_char = "C"; step();
    kp_valid = 0; ux_valid = 0;
    chk("clr_kp_ready_a", kp_ready, 0);
    chk("clr_ux_ready_a", ux_ready, 0);
    step();
    chk("clr_kp_ready_b", kp_ready, 0);
    chk("clr_ux_ready_b", ux_ready, 0);
    step();
    chk("clr_kp_ready_c", kp_ready, 1);
    chk("clr_ux_ready_c", ux_ready, 1);
    repeat (8) step();
    chk("clr_count", pulses.size(), 2);
    if (pulses.size() == 2) begin
      chk("clr_char0", pulses[0].ch, "1");
      chk("clr_time0", pulses[0].cyc, n0 + 2);
      chk("clr_char1", pulses[1].ch, "C");
      chk("clr_time1", pulses[1].cyc, n0 + 5);
    end
    chk("clr_err", err_count, 0);

    // Illegal codes on UART, then saturation of the error counter.
    reset_dut();
    pulses.delete();
    ux_valid = 1; ux_char = "x"; step();
    ux_char = 8'h00; step();
    ux_char = 8'h08; step();
    ux_valid = 0;
    repeat (10) step();
    chk("ill_count", pulses.size(), 1);
    if (pulses.size() > 0) chk("ill_char", pulses[0].ch, 8'h08);
    chk("ill_err", err_count, 2);
    ux_valid = 1; ux_char = "x";
    repeat (300) step();
    ux_valid = 0;
    step();
    chk("ill_err_sat", err_count, 255);

    // Reset mid-pulse with three keys queued.
    reset_dut();
    kp_valid = 1; kp_char = "1"; ux_valid = 1; ux_char = "7"; step();
    kp_char = "2"; ux_char = "3"; step();
    kp_valid = 0; ux_valid = 0;
    chk("mid_pulse_before", btn_valid, 1);
    chk("mid_busy_before", busy, 1);
    rst_n = 0;
    #1;
    chk("mid_rst_btn_valid", btn_valid, 0);
    chk("mid_rst_busy", busy, 0);
    step(); step();
    rst_n = 1;
    pulses.delete();
    repeat (15) step();
    chk("mid_no_pulses", pulses.size(), 0);
    chk("mid_busy_after", busy, 0);
    chk("mid_kp_ready", kp_ready, 1);
    chk("mid_ux_ready", ux_ready, 1);

    // Randomized traffic against the queue model.
    reset_dut();
    mkq.delete(); muq.delete();
    m_clr = 0; m_last_ux = 1; m_err = 0; seen = 0; low_run = 0;
    pk_acc = 0; pu_acc = 0; pk_c = 0; pu_c = 0;
    for (int i = 0; i < 2500; i++) model_step(1'b1);
    for (int i = 0; i < 40; i++) model_step(1'b0);
    chk("rand_kp_drained", mkq.size(), 0);
    chk("rand_ux_drained", muq.size(), 0);
    chk("rand_clr_drained", m_clr, 0);
    chk("rand_busy_end", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
